// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Purpose  : Round-robin owner of the shared multi-cycle divider; latches the
//            winner's operands, drives start/annul, returns the result.
// Revision : 1.0
// ============================================================================
module div_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_i,
  input  logic [DATA_W-1:0]     op1_0_i,
  input  logic [DATA_W-1:0]     op2_0_i,
  input  logic                  signed0_i,
  input  logic                  annul0_i,

  input  logic                  req1_i,
  input  logic [DATA_W-1:0]     op1_1_i,
  input  logic [DATA_W-1:0]     op2_1_i,
  input  logic                  signed1_i,
  input  logic                  annul1_i,

  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  ready0_o,
  output logic                  ready1_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  busy_o,

  output logic                  div_start_o,
  output logic                  div_annul_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opdata1_o,
  output logic [DATA_W-1:0]     div_opdata2_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                ready0_q, ready0_d;
  logic                ready1_q, ready1_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic                signed_q, signed_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic elig0;
  logic elig1;
  logic winner;
  logic owner_gone;
  logic abort_run;

  // On a tie the requester that did not own the divider last time wins.
  always_comb begin
    elig0 = req0_i & ~annul0_i;
    elig1 = req1_i & ~annul1_i;
    if (elig0 && elig1) begin
      winner = ~last_q;
    end else begin
      winner = elig1;
    end
    if (owner_q) begin
      owner_gone = ~req1_i | annul1_i;
    end else begin
      owner_gone = ~req0_i | annul0_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    ready0_d  = ready0_q;
    ready1_d  = ready1_q;
    start_d   = start_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    abort_run = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          state_d  = RUN;
          owner_d  = winner;
          gnt0_d   = ~winner;
          gnt1_d   = winner;
          ready0_d = 1'b0;
          ready1_d = 1'b0;
          start_d  = 1'b1;
          op1_d    = winner ? op1_1_i   : op1_0_i;
          op2_d    = winner ? op2_1_i   : op2_0_i;
          signed_d = winner ? signed1_i : signed0_i;
        end
      end

      RUN: begin
        // A withdrawn owner beats a result arriving in the same cycle.
        if (owner_gone) begin
          abort_run = 1'b1;
          state_d   = IDLE;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          start_d   = 1'b0;
          last_d    = owner_q;
        end else if (div_ready_i) begin
          state_d  = DONE;
          result_d = div_result_i;
          ready0_d = ~owner_q;
          ready1_d = owner_q;
        end
      end

      DONE: begin
        // Start stays high here: the divider keeps ready only while started.
        if (owner_gone) begin
          state_d  = IDLE;
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          ready0_d = 1'b0;
          ready1_d = 1'b0;
          start_d  = 1'b0;
          last_d   = owner_q;
        end
      end

      default: begin
        state_d  = IDLE;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        start_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      start_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
      start_q  <= start_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      result_q <= result_d;
    end
  end

  assign gnt0_o        = gnt0_q;
  assign gnt1_o        = gnt1_q;
  assign ready0_o      = ready0_q;
  assign ready1_o      = ready1_q;
  assign result_o      = result_q;
  assign busy_o        = (state_q != IDLE);
  assign div_start_o   = start_q;
  assign div_annul_o   = abort_run;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Scoreboard bench for div_arbiter with a behavioural divider.
// Revision : 1.0
// ============================================================================
module tb_div_arbiter;
  localparam int DATA_W  = 32;
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              req[2];
  logic              annul[2];
  logic              sgn[2];
  logic [DATA_W-1:0] op1[2];
  logic [DATA_W-1:0] op2[2];

  logic                gnt0_o, gnt1_o, ready0_o, ready1_o, busy_o;
  logic [2*DATA_W-1:0] result_o;
  logic                div_start_o, div_annul_o, div_signed_o;
  logic [DATA_W-1:0]   div_opdata1_o, div_opdata2_o;
  logic [2*DATA_W-1:0] div_result_i = '0;
  logic                div_ready_i  = 1'b0;
  int                  dm_cnt       = 0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  div_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req[0]), .op1_0_i(op1[0]), .op2_0_i(op2[0]), .signed0_i(sgn[0]), .annul0_i(annul[0]),
    .req1_i(req[1]), .op1_1_i(op1[1]), .op2_1_i(op2[1]), .signed1_i(sgn[1]), .annul1_i(annul[1]),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .ready0_o(ready0_o), .ready1_o(ready1_o),
    .result_o(result_o), .busy_o(busy_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  initial forever #5 clk = ~clk;

  // Truncating division; {remainder, quotient}.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider: result appears DIV_LAT cycles into a start, held until start drops.
  always @(posedge clk) begin
    if (rst || !div_start_o || div_annul_o) begin
      dm_cnt      <= 0;
      div_ready_i <= 1'b0;
    end else if (!div_ready_i) begin
      if (dm_cnt == DIV_LAT - 1) begin
        div_ready_i  <= 1'b1;
        div_result_i <= div_ref(div_opdata1_o, div_opdata2_o, div_signed_o);
      end
      dm_cnt <= dm_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic sb_pop(input int p);
    logic [63:0] e;
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      n_chk++;
      $display("FAIL ready%0d_unexpected: got result %h, required no ready", p, result_o);
    end else begin
      if (p == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      chk($sformatf("result%0d", p), result_o, e);
    end
  endtask

  task automatic monitor();
    logic prst, pb, pe0, pe1, pr0, pr1, last;
    logic [1:0]  pg, exp_g;
    logic [63:0] pres;
    prst = 1'b1; pb = 1'b0; pe0 = 1'b0; pe1 = 1'b0; pr0 = 1'b0; pr1 = 1'b0;
    last = 1'b1; pg = 2'b00; pres = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        last = 1'b1;
      end else begin
        chk("invariants",
            {57'd0, gnt0_o & gnt1_o, ready0_o & ready1_o, ready0_o & ~gnt0_o, ready1_o & ~gnt1_o,
             div_annul_o & ~busy_o, div_annul_o & (ready0_o | ready1_o), div_start_o ^ busy_o}, 64'd0);
        if (!prst && !pb) begin
          if (pe0 && pe1) exp_g = last ? 2'b01 : 2'b10;
          else            exp_g = {pe1, pe0};
          chk("grant_choice", {61'd0, busy_o, gnt1_o, gnt0_o}, {61'd0, |exp_g, exp_g});
          if (exp_g != 2'b00) last = exp_g[1];
        end else if (!prst && pb && busy_o) begin
          chk("owner_hold", {62'd0, gnt1_o, gnt0_o}, {62'd0, pg});
        end
        if (ready0_o && !pr0) sb_pop(0);
        if (ready1_o && !pr1) sb_pop(1);
        if ((ready0_o && pr0) || (ready1_o && pr1)) chk("result_hold", result_o, pres);
      end
      prst = rst;
      pb   = busy_o;
      pe0  = req[0] & ~annul[0];
      pe1  = req[1] & ~annul[1];
      pr0  = ready0_o;
      pr1  = ready1_o;
      pg   = {gnt1_o, gnt0_o};
      pres = result_o;
    end
  endtask

  task automatic watchdog();
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input bit push);
    op1[p] = a; op2[p] = b; sgn[p] = s; annul[p] = 1'b0; req[p] = 1'b1;
    if (push) begin
      if (p == 0) exp_q0.push_back(exp);
      else        exp_q1.push_back(exp);
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input bit push);
    @(posedge clk); #1;
    set_req(p, a, b, s, exp, push);
  endtask

  task automatic release_req(input int p);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic wait_ready(input int p);
    int k;
    k = 0;
    while (((p == 0) ? ready0_o : ready1_o) !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk_bit($sformatf("ready%0d_arrives", p), (p == 0) ? ready0_o : ready1_o, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_ctrl"}, {56'd0, gnt0_o, gnt1_o, ready0_o, ready1_o, busy_o, div_start_o,
                          div_annul_o, div_signed_o}, 64'd0);
    chk({name, "_result"}, result_o, 64'd0);
    chk({name, "_opdata"}, {div_opdata1_o, div_opdata2_o}, 64'd0);
  endtask

  task automatic expect_idle_after_release(input string name);
    repeat (2) @(negedge clk);
    chk({name, "_idle"}, {61'd0, busy_o, gnt1_o, gnt0_o}, 64'd0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs(name);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] a, b;
    logic        s;
    bit          abort;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (b == 32'd0) b = 32'd1;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      abort = ($urandom_range(0, 4) == 0);
      issue(p, a, b, s, div_ref(a, b, s), !abort);
      if (abort) begin
        repeat ($urandom_range(1, 25)) @(posedge clk);
        #1;
        annul[p] = 1'($urandom_range(0, 1));
        req[p]   = 1'b0;
        @(posedge clk); #1;
        annul[p] = 1'b0;
      end else begin
        wait_ready(p);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        release_req(p);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; annul[i] = 1'b0; sgn[i] = 1'b0; op1[i] = '0; op2[i] = '0;
    end
    fork
      monitor();
      watchdog();
    join_none

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single unsigned request on port 0.
    issue(0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b1);
    @(negedge clk);
    chk_bit("t1_no_gnt_before_edge", gnt0_o, 1'b0);
    @(negedge clk);
    chk_bit("t1_gnt0_cycle1", gnt0_o, 1'b1);
    chk_bit("t1_start_cycle1", div_start_o, 1'b1);
    wait_ready(0);
    release_req(0);
    expect_idle_after_release("t1");

    // Signed request on port 1.
    issue(1, 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);
    repeat (2) @(negedge clk);
    chk_bit("t2_div_signed", div_signed_o, 1'b1);
    wait_ready(1);
    chk_bit("t2_ready0_low", ready0_o, 1'b0);
    release_req(1);
    expect_idle_after_release("t2");

    // Simultaneous requests right after reset, then alternation.
    do_reset("t3_reset");
    @(posedge clk); #1;
    set_req(0, 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b1);
    set_req(1, 32'd81, 32'd4, 1'b0, {32'd1, 32'd20}, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_first_gnt", {62'd0, gnt1_o, gnt0_o}, 64'd1);
    wait_ready(0);
    release_req(0);
    @(negedge clk);
    @(negedge clk);
    chk_bit("t3_dead_cycle", busy_o, 1'b0);
    @(negedge clk);
    chk("t3_second_gnt", {62'd0, gnt1_o, gnt0_o}, 64'd2);
    issue(0, 32'd9, 32'd2, 1'b0, {32'd1, 32'd4}, 1'b1);
    wait_ready(1);
    release_req(1);
    repeat (3) @(negedge clk);
    chk("t3_third_gnt", {62'd0, gnt1_o, gnt0_o}, 64'd1);
    wait_ready(0);
    release_req(0);
    expect_idle_after_release("t3");

    // Annul on the 10th RUN cycle with port 1 waiting.
    issue(0, 32'd1234, 32'd5, 1'b0, 64'd0, 1'b0);
    issue(1, 32'd777, 32'd3, 1'b0, {32'd0, 32'd259}, 1'b1);
    repeat (9) @(posedge clk);
    #1 annul[0] = 1'b1;
    @(negedge clk);
    chk_bit("t4_annul_pulse", div_annul_o, 1'b1);
    @(posedge clk); #1;
    annul[0] = 1'b0;
    req[0]   = 1'b0;
    @(negedge clk);
    chk("t4_after_annul", {61'd0, div_annul_o, div_start_o, gnt0_o}, 64'd0);
    @(negedge clk);
    chk_bit("t4_gnt1_next", gnt1_o, 1'b1);
    wait_ready(1);
    release_req(1);
    expect_idle_after_release("t4");

    // Operand changes during RUN must not reach the divider.
    issue(0, 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    op1[0] = 32'hDEAD_BEEF;
    op2[0] = 32'd1;
    sgn[0] = 1'b1;
    @(negedge clk);
    chk("t5_opdata_stable", {div_opdata1_o, div_opdata2_o}, {32'd1000, 32'd33});
    chk_bit("t5_signed_stable", div_signed_o, 1'b0);
    wait_ready(0);
    release_req(0);
    expect_idle_after_release("t5");

    // Reset in the middle of RUN with the request still held.
    issue(0, 32'd500, 32'd9, 1'b0, {32'd5, 32'd55}, 1'b1);
    repeat (4) @(posedge clk);
    do_reset("t6_reset");
    exp_q0.push_back({32'd5, 32'd55});
    @(negedge clk);
    chk_bit("t6_regrant", gnt0_o, 1'b1);
    wait_ready(0);
    release_req(0);
    expect_idle_after_release("t6");

    // Randomized contention on both ports.
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
